// File: rtl/formation_march_ctrl.sv
// Alien formation step controller: paces the march by live alien count and walks the
// march-right / drop / march-left / drop cycle, freezing for good once the formation lands.
module formation_march_ctrl #(
    parameter int unsigned XSTEP       = 2,
    parameter int unsigned YSTEP       = 2,
    parameter int unsigned DROP_STEPS  = 4,
    parameter int unsigned RIGHT_LIMIT = 630,
    parameter int unsigned LEFT_LIMIT  = 6,
    parameter int unsigned LAND_Y      = 440,
    parameter int unsigned H_LAST      = 639,
    parameter int unsigned V_LAST      = 479
) (
    input  logic       Pclk,
    input  logic       rst,
    input  logic [9:0] xx,
    input  logic [9:0] yy,
    input  logic [9:0] LeftX,
    input  logic [9:0] RightX,
    input  logic [9:0] BottomY,
    input  logic [5:0] AlienCount,
    output logic [1:0] X_off,
    output logic       Xdir,
    output logic [1:0] Y_off,
    output logic       StepEn,
    output logic       Landed
);

    localparam logic [2:0] ST_MARCH_R = 3'd0;
    localparam logic [2:0] ST_DROP_R  = 3'd1;
    localparam logic [2:0] ST_MARCH_L = 3'd2;
    localparam logic [2:0] ST_DROP_L  = 3'd3;
    localparam logic [2:0] ST_LANDED  = 3'd4;

    logic [2:0] state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [1:0] dcnt_q, dcnt_d;
    logic [1:0] x_off_q, x_off_d;
    logic       xdir_q, xdir_d;
    logic [1:0] y_off_q, y_off_d;
    logic       step_en_q, step_en_d;
    logic       landed_q, landed_d;

    logic       tick;
    logic       alive;
    logic       step;
    logic [2:0] period_m1;

    always_comb begin
        tick      = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));
        alive     = (AlienCount != 6'd0);
        period_m1 = AlienCount[5:3];
        // Step only when the armed frame ends with aliens present and not yet landed.
        step      = tick && step_en_q && alive && (state_q != ST_LANDED);

        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (step) begin
            if (BottomY >= 10'(LAND_Y)) begin
                state_d = ST_LANDED;
            end else begin
                case (state_q)
                    ST_MARCH_R: begin
                        if (RightX >= 10'(RIGHT_LIMIT)) begin
                            state_d = ST_DROP_R;
                            dcnt_d  = 2'(DROP_STEPS - 1);
                        end
                    end
                    ST_DROP_R: begin
                        if (dcnt_q == 2'd0) state_d = ST_MARCH_L;
                        else                dcnt_d  = dcnt_q - 2'd1;
                    end
                    ST_MARCH_L: begin
                        if (LeftX <= 10'(LEFT_LIMIT)) begin
                            state_d = ST_DROP_L;
                            dcnt_d  = 2'(DROP_STEPS - 1);
                        end
                    end
                    ST_DROP_L: begin
                        if (dcnt_q == 2'd0) state_d = ST_MARCH_R;
                        else                dcnt_d  = dcnt_q - 2'd1;
                    end
                    default: ;
                endcase
            end
        end

        fcnt_d    = fcnt_q;
        step_en_d = step_en_q;
        x_off_d   = x_off_q;
        xdir_d    = xdir_q;
        y_off_d   = y_off_q;
        landed_d  = landed_q;
        if (tick) begin
            landed_d = (state_d == ST_LANDED);
            if (!alive || landed_d)         fcnt_d = 3'd0;
            else if (fcnt_q >= period_m1)   fcnt_d = 3'd0;
            else                            fcnt_d = fcnt_q + 3'd1;
            step_en_d = (fcnt_d == period_m1) && alive && !landed_d;

            case (state_d)
                ST_MARCH_R: begin x_off_d = 2'(XSTEP); xdir_d = 1'b1; y_off_d = 2'd0;       end
                ST_DROP_R:  begin x_off_d = 2'd0;      xdir_d = 1'b1; y_off_d = 2'(YSTEP);  end
                ST_MARCH_L: begin x_off_d = 2'(XSTEP); xdir_d = 1'b0; y_off_d = 2'd0;       end
                ST_DROP_L:  begin x_off_d = 2'd0;      xdir_d = 1'b0; y_off_d = 2'(YSTEP);  end
                default:    begin x_off_d = 2'd0;                     y_off_d = 2'd0;       end
            endcase
        end
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            state_q   <= ST_MARCH_R;
            fcnt_q    <= 3'd0;
            dcnt_q    <= 2'd0;
            x_off_q   <= 2'(XSTEP);
            xdir_q    <= 1'b1;
            y_off_q   <= 2'd0;
            step_en_q <= 1'b0;
            landed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            dcnt_q    <= dcnt_d;
            x_off_q   <= x_off_d;
            xdir_q    <= xdir_d;
            y_off_q   <= y_off_d;
            step_en_q <= step_en_d;
            landed_q  <= landed_d;
        end
    end

    assign X_off  = x_off_q;
    assign Xdir   = xdir_q;
    assign Y_off  = y_off_q;
    assign StepEn = step_en_q;
    assign Landed = landed_q;

endmodule

// File: tb/tb_formation_march_ctrl.sv
// Scoreboard bench for formation_march_ctrl on a shrunken raster (8x4 pixels per frame).
module tb_formation_march_ctrl;

    localparam int unsigned HL = 7;
    localparam int unsigned VL = 3;

    logic       Pclk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] xx = '0, yy = '0;
    logic [9:0] LeftX = 10'd50, RightX = 10'd100, BottomY = 10'd200;
    logic [5:0] AlienCount = 6'd5;
    logic [1:0] X_off, Y_off;
    logic       Xdir, StepEn, Landed;

    formation_march_ctrl #(.H_LAST(HL), .V_LAST(VL)) dut (
        .Pclk       (Pclk),
        .rst        (rst),
        .xx         (xx),
        .yy         (yy),
        .LeftX      (LeftX),
        .RightX     (RightX),
        .BottomY    (BottomY),
        .AlienCount (AlienCount),
        .X_off      (X_off),
        .Xdir       (Xdir),
        .Y_off      (Y_off),
        .StepEn     (StepEn),
        .Landed     (Landed)
    );

    always #5 Pclk = ~Pclk;

    int n_checks = 0;
    int n_errors = 0;
    int steps_seen = 0;
    logic [6:0] exp_q[$];

    // Frame-level reference model: 0 MARCH_R, 1 DROP_R, 2 MARCH_L, 3 DROP_L, 4 LANDED.
    int m_st, m_fcnt, m_drops_left;
    bit m_step, m_landed, m_xdir;
    int m_xoff, m_yoff;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_vec();
        return {2'(m_xoff), m_xdir, 2'(m_yoff), m_step, m_landed};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_fcnt = 0; m_drops_left = 0;
        m_step = 0; m_landed = 0;
        m_xoff = 2; m_xdir = 1; m_yoff = 0;
    endfunction

    function automatic void model_tick();
        int p;
        bit alive;
        p = int'(AlienCount) / 8 + 1;
        alive = (AlienCount != 0);
        if (alive && !m_landed && m_step) begin
            if (BottomY >= 440) begin
                m_st = 4;
                m_landed = 1;
            end else if (m_st == 0 && RightX >= 630) begin
                m_st = 1; m_drops_left = 4;
            end else if (m_st == 2 && LeftX <= 6) begin
                m_st = 3; m_drops_left = 4;
            end else if (m_st == 1 || m_st == 3) begin
                m_drops_left--;
                if (m_drops_left == 0) m_st = (m_st == 1) ? 2 : 0;
            end
        end
        if (!alive || m_landed || m_fcnt >= p - 1) m_fcnt = 0;
        else                                       m_fcnt++;
        m_step = alive && !m_landed && (m_fcnt == p - 1);
        m_xoff = (m_st == 0 || m_st == 2) ? 2 : 0;
        m_yoff = (m_st == 1 || m_st == 3) ? 2 : 0;
        if (m_st < 4) m_xdir = (m_st <= 1);
    endfunction

    task automatic pop_compare(input string tag);
        logic [6:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 0, 1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, int'({X_off, Xdir, Y_off, StepEn, Landed}), int'(exp));
        end
    endtask

    task automatic run_frame();
        for (int y = 0; y <= int'(VL); y++) begin
            for (int x = 0; x <= int'(HL); x++) begin
                xx = 10'(x);
                yy = 10'(y);
                if (x == int'(HL) && y == int'(VL)) begin
                    model_tick();
                    exp_q.push_back(model_vec());
                end
                @(posedge Pclk);
                #1;
                if (x == int'(HL) && y == int'(VL)) begin
                    pop_compare("frame");
                    if (StepEn) steps_seen++;
                end
            end
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    // Reset is asserted on a tick pixel so it must win over the tick.
    task automatic do_reset();
        xx = 10'(HL);
        yy = 10'(VL);
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_vec());
        @(posedge Pclk);
        #1;
        rst = 1'b0;
        xx = '0;
        yy = '0;
        pop_compare("reset");
    endtask

    initial begin
        do_reset();
        check("rst_xoff", int'(X_off), 2);
        check("rst_xdir", int'(Xdir), 1);
        check("rst_stepen", int'(StepEn), 0);

        // Basic march, P=1
        run_frames(3);
        check("march_stepen", int'(StepEn), 1);
        check("march_xoff", int'(X_off), 2);
        check("march_xdir", int'(Xdir), 1);

        // Right-edge turn: four drop frames then march left
        RightX = 10'd630;
        run_frame();
        RightX = 10'd100;
        check("drop_r_xoff", int'(X_off), 0);
        check("drop_r_yoff", int'(Y_off), 2);
        run_frames(3);
        check("drop_r_still", int'(Y_off), 2);
        run_frame();
        check("marchl_xoff", int'(X_off), 2);
        check("marchl_xdir", int'(Xdir), 0);
        check("marchl_yoff", int'(Y_off), 0);

        // Speed scaling: P=6 then P=1
        AlienCount = 6'd40;
        steps_seen = 0;
        run_frames(12);
        check("p6_steps", steps_seen, 2);
        AlienCount = 6'd7;
        steps_seen = 0;
        run_frames(3);
        check("p1_steps", steps_seen, 3);

        // Wave cleared: hold, then resume leftwards
        AlienCount = 6'd0;
        steps_seen = 0;
        run_frames(5);
        check("clear_steps", steps_seen, 0);
        check("clear_xdir", int'(Xdir), 0);
        AlienCount = 6'd3;
        run_frame();
        check("resume_stepen", int'(StepEn), 1);
        check("resume_xdir", int'(Xdir), 0);

        // Left-edge turn, then reset mid-drop
        LeftX = 10'd6;
        run_frame();
        LeftX = 10'd50;
        check("drop_l_yoff", int'(Y_off), 2);
        check("drop_l_xdir", int'(Xdir), 0);
        run_frame();
        for (int i = 0; i < 5; i++) begin
            xx = 10'(i);
            yy = '0;
            @(posedge Pclk);
            #1;
        end
        do_reset();
        check("midrst_xdir", int'(Xdir), 1);
        check("midrst_xoff", int'(X_off), 2);
        check("midrst_yoff", int'(Y_off), 0);
        check("midrst_stepen", int'(StepEn), 0);

        // Landing beats the right-edge turn
        AlienCount = 6'd5;
        RightX = 10'd630;
        BottomY = 10'd440;
        run_frames(2);
        check("land_flag", int'(Landed), 1);
        check("land_stepen", int'(StepEn), 0);
        check("land_xoff", int'(X_off), 0);
        check("land_yoff", int'(Y_off), 0);
        steps_seen = 0;
        run_frames(100);
        check("land_hold_steps", steps_seen, 0);
        check("land_hold_flag", int'(Landed), 1);
        BottomY = 10'd200;
        RightX = 10'd100;
        do_reset();
        check("unland_flag", int'(Landed), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
